out_port_sched: RTL and testbench

OUT_PORT_SCHED -- requirements
Module: out_port_sched

---
 rtl/out_port_sched.sv | 174 +++++++++++++++++
 tb/tb_out_port_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/out_port_sched.sv
// Output-port scheduler: round-robin arbitration of five input FIFOs onto one
// credit-flow-controlled output. Optional grant counter under SCHED_STATS_EN.
module out_port_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req_i,
    input  logic          credit_inc_i,
    output logic [4:0]    grant_o,
    output logic [4:0]    pop_o,
    output logic [2:0]    port_select_o,
    output logic          send_en_o,
    output logic [CW-1:0] credits_o,
    output logic          full_o,
`ifdef SCHED_STATS_EN
    output logic [15:0]   grant_cnt_o,
`endif
    output logic          cred_err_o
);

    localparam int unsigned N_IN  = 5;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned IDX_W = 4;
    localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;
    localparam logic [CW-1:0]    CRED_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_CRED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   psel_q, psel_d;
    logic [N_IN-1:0]    grant_q, grant_d;
    logic [N_IN-1:0]    pop_q, pop_d;
    logic               send_q, send_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic               cred_err_q, cred_err_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_sum;
    logic [SEL_W-1:0]   cand;

    // Round-robin search starting at ptr_q, wrapping modulo five.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            cand_sum = IDX_W'(ptr_q) + IDX_W'(i);
            if (cand_sum >= IDX_W'(N_IN)) begin
                cand_sum = cand_sum - IDX_W'(N_IN);
            end
            cand = SEL_W'(cand_sum);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output decode; strobes are loaded on GRANT entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        psel_d  = SEL_NONE;
        grant_d = '0;
        pop_d   = '0;
        send_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    if (credits_q != '0 && win_found) begin
                        state_d = ST_GRANT;
                        psel_d  = win_idx;
                        grant_d = N_IN'(1) << win_idx;
                        pop_d   = N_IN'(1) << win_idx;
                        send_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_CRED;
                    end
                end
            end
            ST_GRANT: begin
                state_d = ST_IDLE;
                ptr_d   = (psel_q == SEL_W'(N_IN - 1)) ? '0 : psel_q + SEL_W'(1);
            end
            ST_WAIT_CRED: begin
                if (credits_q != '0 || !(|req_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Credit counter; a return with the count already full is an overflow.
    always_comb begin
        credits_d  = credits_q;
        cred_err_d = cred_err_q;
        unique case ({send_q, credit_inc_i})
            2'b10: credits_d = credits_q - CW'(1);
            2'b01: begin
                if (credits_q == CRED_MAX) begin
                    cred_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            psel_q     <= SEL_NONE;
            grant_q    <= '0;
            pop_q      <= '0;
            send_q     <= 1'b0;
            credits_q  <= CRED_MAX;
            cred_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            psel_q     <= psel_d;
            grant_q    <= grant_d;
            pop_q      <= pop_d;
            send_q     <= send_d;
            credits_q  <= credits_d;
            cred_err_q <= cred_err_d;
        end
    end

    assign grant_o       = grant_q;
    assign pop_o         = pop_q;
    assign port_select_o = psel_q;
    assign send_en_o     = send_q;
    assign credits_o     = credits_q;
    assign full_o        = (credits_q == '0);
    assign cred_err_o    = cred_err_q;

`ifdef SCHED_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    // Counts completed GRANT cycles, wrapping naturally at 16 bits.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (send_q) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_out_port_sched.sv
// Directed self-checking bench for out_port_sched (default DEPTH=4, CW=3).
module tb_out_port_sched;

    logic       clk;
    logic       rst;
    logic [4:0] req_i;
    logic       credit_inc_i;
    logic [4:0] grant_o;
    logic [4:0] pop_o;
    logic [2:0] port_select_o;
    logic       send_en_o;
    logic [2:0] credits_o;
    logic       full_o;
    logic       cred_err_o;
`ifdef SCHED_STATS_EN
    logic [15:0] grant_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    out_port_sched #(.DEPTH(4), .CW(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .credit_inc_i  (credit_inc_i),
        .grant_o       (grant_o),
        .pop_o         (pop_o),
        .port_select_o (port_select_o),
        .send_en_o     (send_en_o),
        .credits_o     (credits_o),
        .full_o        (full_o),
`ifdef SCHED_STATS_EN
        .grant_cnt_o   (grant_cnt_o),
`endif
        .cred_err_o    (cred_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_i        = '0;
        credit_inc_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [4:0] oh;
        oh = 5'd1 << idx;
        check_eq({tag, "_grant"}, 32'(grant_o), 32'(oh));
        check_eq({tag, "_pop"}, 32'(pop_o), 32'(oh));
        check_eq({tag, "_sel"}, 32'(port_select_o), 32'(idx));
        check_eq({tag, "_send"}, 32'(send_en_o), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, "_grant0"}, 32'(grant_o), 32'd0);
        check_eq({tag, "_sel7"}, 32'(port_select_o), 32'd7);
        check_eq({tag, "_send0"}, 32'(send_en_o), 32'd0);
    endtask

    int order[6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        rst          = 1'b1;
        req_i        = '0;
        credit_inc_i = 1'b0;
        #2;
        // Reset state
        expect_idle("rst");
        check_eq("rst_pop", 32'(pop_o), 32'd0);
        check_eq("rst_credits", 32'(credits_o), 32'd4);
        check_eq("rst_full", 32'(full_o), 32'd0);
        check_eq("rst_err", 32'(cred_err_o), 32'd0);
`ifdef SCHED_STATS_EN
        check_eq("rst_cnt", 32'(grant_cnt_o), 32'd0);
`endif
        step();
        rst = 1'b0;

        // Single request from reset: granted one cycle later, credit consumed
        req_i = 5'b00001;
        step();
        expect_grant("s1", 0);
        check_eq("s1_cred_in_grant", 32'(credits_o), 32'd4);
        req_i = 5'b00000;
        step();
        expect_idle("s1_after");
        check_eq("s1_credits", 32'(credits_o), 32'd3);
`ifdef SCHED_STATS_EN
        check_eq("s1_cnt", 32'(grant_cnt_o), 32'd1);
`endif

        // All requesting, credit returned with every send: strict rotation
        do_reset();
        req_i = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            step();
            expect_grant($sformatf("rr%0d", k), order[k]);
            credit_inc_i = 1'b1;
            step();
            credit_inc_i = 1'b0;
            check_eq($sformatf("rr%0d_gap", k), 32'(send_en_o), 32'd0);
            check_eq($sformatf("rr%0d_cred", k), 32'(credits_o), 32'd4);
        end
        req_i = '0;

        // Credit exhaustion and recovery
        do_reset();
        req_i = 5'b00100;
        for (int k = 0; k < 4; k++) begin
            step();
            expect_grant($sformatf("ex%0d", k), 2);
            step();
            check_eq($sformatf("ex%0d_cred", k), 32'(credits_o), 32'(3 - k));
        end
        check_eq("ex_full", 32'(full_o), 32'd1);
        step();
        expect_idle("ex_wait0");
        step();
        expect_idle("ex_wait1");
        credit_inc_i = 1'b1;
        step();
        credit_inc_i = 1'b0;
        check_eq("ex_cred_back", 32'(credits_o), 32'd1);
        check_eq("ex_full_clr", 32'(full_o), 32'd0);
        check_eq("ex_wait2_send", 32'(send_en_o), 32'd0);
        step();
        check_eq("ex_idle_send", 32'(send_en_o), 32'd0);
        step();
        expect_grant("ex_regrant", 2);
        req_i = '0;
        step();
        check_eq("ex_cred_zero", 32'(credits_o), 32'd0);
        check_eq("ex_full_again", 32'(full_o), 32'd1);

        // Return and send in the same cycle at credits=2
        do_reset();
        req_i = 5'b00001;
        step();
        step();
        step();
        step();
        check_eq("both_pre", 32'(credits_o), 32'd2);
        step();
        expect_grant("both", 0);
        credit_inc_i = 1'b1;
        req_i        = '0;
        step();
        credit_inc_i = 1'b0;
        check_eq("both_cred", 32'(credits_o), 32'd2);

        // Overflow: return with count already at DEPTH
        do_reset();
        credit_inc_i = 1'b1;
        step();
        credit_inc_i = 1'b0;
        check_eq("ovf_cred", 32'(credits_o), 32'd4);
        check_eq("ovf_err", 32'(cred_err_o), 32'd1);
        step();
        step();
        check_eq("ovf_sticky", 32'(cred_err_o), 32'd1);
        do_reset();
        check_eq("ovf_clr", 32'(cred_err_o), 32'd0);

        // Reset in the middle of GRANT drops strobes immediately
        req_i = 5'b00010;
        step();
        expect_grant("rg_pre", 1);
        rst = 1'b1;
        #1;
        expect_idle("rg");
        check_eq("rg_pop", 32'(pop_o), 32'd0);
        check_eq("rg_cred", 32'(credits_o), 32'd4);
`ifdef SCHED_STATS_EN
        check_eq("rg_cnt", 32'(grant_cnt_o), 32'd0);
`endif
        step();
        check_eq("rg_cred_hold", 32'(credits_o), 32'd4);
        rst   = 1'b0;
        req_i = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
